// File: rtl/vector_sweep_misr.sv
// vector_sweep_misr: applies every N-bit vector (binary or Gray order) to a
// DUT, holds each for HOLD cycles and folds the sampled response into a
// 16-bit MISR signature.
module vector_sweep_misr #(
  parameter int          N    = 5,
  parameter int          M    = 1,
  parameter int          HOLD = 2,
  parameter int          MODE = 0,
  parameter logic [15:0] SEED = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [M-1:0] resp,
  output logic [N-1:0] vec,
  output logic         vec_valid,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic [15:0]  sig,
  output logic [N:0]   vec_count
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N-1:0] IDX_LAST  = '1;
  localparam logic [N-1:0] IDX_ONE   = 1;
  localparam logic [N:0]   CNT_ONE   = 1;
  localparam logic [15:0]  POLY      = 16'h6801;

  state_t       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [7:0]   hold_q, hold_d;
  logic [15:0]  sig_q, sig_d;
  logic [N:0]   cnt_q, cnt_d;
  logic         abt_q, abt_d;

  logic [15:0]  resp_ext;
  logic [15:0]  misr_next;
  logic [N-1:0] vec_run;

  assign resp_ext  = 16'(resp);
  assign misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ resp_ext;
  // Gray order flips exactly one input bit between consecutive vectors.
  assign vec_run   = (MODE == 1) ? (idx_q ^ (idx_q >> 1)) : idx_q;

  // Next-state: sweep sequencing, hold timing, sampling and abort handling.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    abt_d   = abt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          hold_d  = '0;
          sig_d   = SEED;
          cnt_d   = '0;
          abt_d   = 1'b0;
        end
      end
      RUN: begin
        // Abort takes priority, even over the final sample of the sweep.
        if (abort) begin
          state_d = IDLE;
          abt_d   = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          sig_d  = misr_next;
          cnt_d  = cnt_q + CNT_ONE;
          hold_d = '0;
          if (idx_q == IDX_LAST) state_d = FINISH;
          else                   idx_d   = idx_q + IDX_ONE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      sig_q   <= SEED;
      cnt_q   <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      abt_q   <= abt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign vec_valid = busy;
  assign done      = (state_q == FINISH);
  assign vec       = busy ? vec_run : '0;
  assign aborted   = abt_q;
  assign sig       = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_vector_sweep_misr.sv
// Bench for vector_sweep_misr: randomized sweeps on a Gray/HOLD=2 instance
// against a cycle-indexed model, plus two small fixed-response instances.
module tb_vector_sweep_misr;

  localparam int          NA = 3, MA = 4, HA = 2, MODEA = 1;
  localparam logic [15:0] SEEDA = 16'hACE1;
  localparam int          TOT = (1 << NA) * HA;

  logic clk = 1'b0;
  logic rst, start, abort, start2, abort2;
  logic [MA-1:0] resp;
  logic [0:0]    resp2, resp3;

  logic [NA-1:0] vec;
  logic vld, busy, done, abt;
  logic [15:0] sig;
  logic [NA:0] cnt;

  logic [1:0] vec2;
  logic vld2, busy2, done2, abt2;
  logic [15:0] sig2;
  logic [2:0] cnt2;

  logic [4:0] vec3;
  logic vld3, busy3, done3, abt3;
  logic [15:0] sig3;
  logic [5:0] cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_sweep_misr #(.N(NA), .M(MA), .HOLD(HA), .MODE(MODEA), .SEED(SEEDA)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .vec(vec), .vec_valid(vld), .busy(busy), .done(done), .aborted(abt),
    .sig(sig), .vec_count(cnt));

  vector_sweep_misr #(.N(2), .M(1), .HOLD(1), .MODE(0), .SEED(16'h0000)) u_b (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .resp(resp2),
    .vec(vec2), .vec_valid(vld2), .busy(busy2), .done(done2), .aborted(abt2),
    .sig(sig2), .vec_count(cnt2));

  vector_sweep_misr #(.N(5), .M(1), .HOLD(1), .MODE(0), .SEED(16'h0001)) u_c (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .resp(resp3),
    .vec(vec3), .vec_valid(vld3), .busy(busy3), .done(done3), .aborted(abt3),
    .sig(sig3), .vec_count(cnt3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] r);
    return ((s << 1) & 16'hFFFF) ^ (s[15] ? 16'h6801 : 16'h0000) ^ r;
  endfunction

  function automatic int order(input int i);
    return (MODEA == 1) ? (i ^ (i >> 1)) : i;
  endfunction

  task automatic chk_idle_a(input string tag, input logic [15:0] es, input int ec, input logic ea);
    chk({tag, "_vec"}, vec, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_abt"}, abt, ea);
    chk({tag, "_sig"}, sig, es);
    chk({tag, "_cnt"}, cnt, ec);
  endtask

  // Full sweep on instance A; ab_cyc / rs_cyc select the sweep cycle (1-based)
  // in which abort or reset is raised, 0 for none.
  task automatic sweep(input int ab_cyc, input int rs_cyc);
    logic [15:0] ms;
    int mc;
    ms = SEEDA;
    mc = 0;
    start = 1'b1;
    resp  = MA'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= TOT; k++) begin
      chk("run_vec", vec, order((k - 1) / HA));
      chk("run_vld", vld, 1);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_sig", sig, ms);
      chk("run_cnt", cnt, mc);
      resp  = MA'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if (k == rs_cyc) begin
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        chk_idle_a("rst", SEEDA, 0, 1'b0);
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_idle_a("rst_after", SEEDA, 0, 1'b0);
        return;
      end
      if (k == ab_cyc) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk_idle_a("abt", ms, mc, 1'b1);
        @(negedge clk);
        chk_idle_a("abt_hold", ms, mc, 1'b1);
        return;
      end
      if (k % HA == 0) begin
        ms = misr(ms, 16'(resp));
        mc++;
      end
      @(negedge clk);
    end
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_vld", vld, 0);
    chk("fin_vec", vec, 0);
    chk("fin_abt", abt, 0);
    chk("fin_sig", sig, ms);
    chk("fin_cnt", cnt, mc);
    // start and abort during FINISH must both be ignored
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_idle_a("post", ms, mc, 1'b0);
    @(negedge clk);
    chk_idle_a("post2", ms, mc, 1'b0);
  endtask

  initial begin
    logic [15:0] s32;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    resp = '0; resp2 = 1'b1; resp3 = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_a("reset", SEEDA, 0, 1'b0);
    chk("reset_b_sig", sig2, 0);
    chk("reset_c_sig", sig3, 1);
    rst = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle_a("idle_abort", SEEDA, 0, 1'b0);

    repeat (3) sweep(0, 0);
    repeat (3) sweep($urandom_range(1, TOT - 1), 0);
    sweep(TOT, 0);
    sweep(0, 0);
    repeat (2) sweep(0, $urandom_range(1, TOT));
    sweep(0, 0);

    // Fixed-response instances: binary N=2 and the N=5 MISR shift check.
    s32 = 16'h0001;
    for (int i = 0; i < 32; i++) s32 = misr(s32, 16'h0000);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k <= 4) begin
        chk("b_vec", vec2, k - 1);
        chk("b_vld", vld2, 1);
        chk("b_done", done2, 0);
      end
      if (k == 5) begin
        chk("b_done5", done2, 1);
        chk("b_sig", sig2, 16'h000F);
        chk("b_cnt", cnt2, 4);
      end
      if (k == 6) chk("b_done6", done2, 0);
      if (k == 17) chk("c_sig16", sig3, 16'h6801);
      if (k <= 32) chk("c_done", done3, 0);
      if (k == 33) begin
        chk("c_done33", done3, 1);
        chk("c_sig32", sig3, s32);
        chk("c_cnt", cnt3, 32);
      end
      @(negedge clk);
    end
    chk("c_done_end", done3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_sweep_misr.md
VECTOR_SWEEP_MISR -- requirements
Module: vector_sweep_misr

Interface
REQ-001 SHALL have parameter N, default 5: width of the applied input vector, valid range 1..16.
REQ-002 SHALL have parameter M, default 1: width of the DUT response, valid range 1..16.
REQ-003 SHALL have parameter HOLD, default 2: clock cycles each vector is held, valid range 1..255.
REQ-004 SHALL have parameter MODE, default 0: sweep order, 0 = ascending binary, 1 = reflected Gray code.
REQ-005 SHALL have parameter SEED, default 16'h0000: MISR value loaded on start.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-009 SHALL have port abort, input, 1 bit: terminates a running sweep.
REQ-010 SHALL have port resp, input, M bits: DUT response to the current vector.
REQ-011 SHALL have port vec, output, N bits: stimulus vector driven to the DUT.
REQ-012 SHALL have port vec_valid, output, 1 bit: vec is a live stimulus.
REQ-013 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on sweep completion.
REQ-015 SHALL have port aborted, output, 1 bit: sticky flag, set when the last sweep was aborted.
REQ-016 SHALL have port sig, output, 16 bits: MISR signature.
REQ-017 SHALL have port vec_count, output, N+1 bits: number of vectors whose responses have been sampled.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and FINISH.
REQ-019 IDLE -> RUN on start=1; the same edge loads sig=SEED, index=0, hold counter=0, vec_count=0 and clears aborted.
REQ-020 In RUN, vec SHALL equal index (MODE 0) or index^(index>>1) (MODE 1), with vec_valid=1 and busy=1.
REQ-021 Each vector SHALL be held exactly HOLD cycles; resp SHALL be sampled on the last hold cycle only.
REQ-022 On each sample, sig_next = ((sig<<1) & 16'hFFFF) ^ (sig[15] ? 16'h6801 : 0) ^ zero-extended resp, and vec_count SHALL increment by 1.
REQ-023 index SHALL advance by 1 after each sample. On the sample of index 2^N-1, the FSM SHALL go RUN -> FINISH with no wrap to 0.
REQ-024 FINISH SHALL last one cycle with done=1, busy=0 and vec_valid=0, then go to IDLE.
REQ-025 Sweep latency SHALL be: vec=0 valid on the cycle after start is sampled, and done high exactly 2^N*HOLD+1 cycles after that start edge.
REQ-026 start while busy=1 or in FINISH SHALL be ignored.
REQ-027 abort=1 in RUN SHALL go to IDLE on the next edge, set aborted=1, assert no done, and freeze sig and vec_count.
REQ-028 If abort and the final sample occur on the same edge, abort SHALL win: no done, and the final response is not accumulated.
REQ-029 abort in IDLE or FINISH SHALL have no effect.
REQ-030 sig and vec_count SHALL hold their values in IDLE until the next start.
REQ-031 vec SHALL read 0 whenever vec_valid=0.

Reset
REQ-032 rst=1 SHALL on the next edge force IDLE and drive vec=0, vec_valid=0, busy=0, done=0, aborted=0, sig=SEED and vec_count=0.
REQ-033 rst SHALL override start and abort on the same edge, including mid-sweep, with no done pulse.

Verification
REQ-034 N=2, HOLD=1, SEED=0, resp=1 constant, start pulse -> vec sequence 0,1,2,3; done one cycle later; sig=16'h000F; vec_count=4.
REQ-035 N=3, MODE=1, HOLD=2 -> vec sequence 0,1,3,2,6,7,5,4, each value held 2 cycles; done 17 cycles after the start edge.
REQ-036 N=5, HOLD=1, resp=0 constant, SEED=16'h0001 -> sig=16'h6801 after 16 samples; final sig after 32 samples checked against a software model of REQ-022.
REQ-037 N=3, HOLD=1: abort on the 4th sample cycle -> aborted=1, vec_count=3, no done, busy=0 on the next cycle.
REQ-038 rst asserted mid-sweep -> all outputs at reset values on the next edge; a fresh start then completes a normal sweep.
REQ-039 Second start during busy -> sweep unaffected and a single done pulse.
